branch_resolve_unit: RTL and testbench

Sits directly downstream of the branch comparator in the ID stage. Latches the comparator flags together with the branch type, PC and offset of the branch instruction, then decides taken/not-taken. Issues a single-cycle PC redirect with target and holds a pipeline flush for a fixed number of cycles. Keeps saturating branch/taken statistics counters for the lab CPU debug display.

---
 rtl/branch_resolve_unit.sv | 132 +++++++++++++
 tb/tb_branch_resolve_unit.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/branch_resolve_unit.sv
// Branch resolve unit: latches comparator flags and branch info in ID, decides
// taken/not-taken, issues a one-cycle PC redirect and a timed flush, keeps statistics.
module branch_resolve_unit #(
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned COUNT_W      = 16
) (
  input  logic               Clk,
  input  logic               Rst_n,
  input  logic               Valid_in,
  input  logic [2:0]         BrType,
  input  logic [31:0]        PC_in,
  input  logic [31:0]        Offset,
  input  logic               beq,
  input  logic               blt,
  input  logic               bgt,
  input  logic               bltz,
  input  logic               bgtz,
  input  logic               Stall,
  output logic               PCSrc,
  output logic [31:0]        BranchTarget,
  output logic               Flush,
  output logic               Busy,
  output logic [COUNT_W-1:0] BranchCount,
  output logic [COUNT_W-1:0] TakenCount
);

  typedef enum logic [1:0] {IDLE, EVAL, FLUSH} state_t;

  typedef enum logic [2:0] {
    BR_NONE, BR_EQ, BR_NE, BR_LT, BR_GT, BR_LTZ, BR_GTZ, BR_JUMP
  } br_t;

  state_t      state;
  br_t         br_type_q;
  logic [31:0] pc_q;
  logic [31:0] off_q;
  logic        beq_q, blt_q, bgt_q, bltz_q, bgtz_q;
  logic [3:0]  flush_cnt;
  logic        taken;
  logic [31:0] target;

  // Only the flag selected by the latched type matters; multi-hot flags are harmless.
  always_comb begin
    taken = 1'b0;
    case (br_type_q)
      BR_EQ:   taken = beq_q;
      BR_NE:   taken = !beq_q;
      BR_LT:   taken = blt_q;
      BR_GT:   taken = bgt_q;
      BR_LTZ:  taken = bltz_q;
      BR_GTZ:  taken = bgtz_q;
      BR_JUMP: taken = 1'b1;
      default: taken = 1'b0;
    endcase
  end

  // Word offset shift drops Offset[31:30]; the sum wraps modulo 2^32.
  assign target = pc_q + 32'd4 + (off_q << 2);

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state        <= IDLE;
      br_type_q    <= BR_NONE;
      pc_q         <= '0;
      off_q        <= '0;
      beq_q        <= 1'b0;
      blt_q        <= 1'b0;
      bgt_q        <= 1'b0;
      bltz_q       <= 1'b0;
      bgtz_q       <= 1'b0;
      flush_cnt    <= '0;
      PCSrc        <= 1'b0;
      BranchTarget <= '0;
      Flush        <= 1'b0;
      Busy         <= 1'b0;
      BranchCount  <= '0;
      TakenCount   <= '0;
    end else begin
      PCSrc <= 1'b0;
      case (state)
        IDLE: begin
          if (Valid_in && (BrType != 3'd0) && !Stall) begin
            br_type_q <= br_t'(BrType);
            pc_q      <= PC_in;
            off_q     <= Offset;
            beq_q     <= beq;
            blt_q     <= blt;
            bgt_q     <= bgt;
            bltz_q    <= bltz;
            bgtz_q    <= bgtz;
            Busy      <= 1'b1;
            state     <= EVAL;
          end
        end
        EVAL: begin
          if (!Stall) begin
            if (BranchCount != '1)
              BranchCount <= BranchCount + COUNT_W'(1);
            if (taken) begin
              PCSrc        <= 1'b1;
              BranchTarget <= target;
              Flush        <= 1'b1;
              flush_cnt    <= 4'(FLUSH_CYCLES - 1);
              if (TakenCount != '1)
                TakenCount <= TakenCount + COUNT_W'(1);
              state        <= FLUSH;
            end else begin
              Busy  <= 1'b0;
              state <= IDLE;
            end
          end
        end
        FLUSH: begin
          // Flush outranks Stall: the countdown never pauses.
          if (flush_cnt == '0) begin
            Flush <= 1'b0;
            Busy  <= 1'b0;
            state <= IDLE;
          end else begin
            flush_cnt <= flush_cnt - 4'd1;
          end
        end
        default: begin
          Flush <= 1'b0;
          Busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Scoreboard bench for branch_resolve_unit: the driver queues expected outcomes,
// a negedge monitor pops and compares each time a branch finishes (Busy falls).
module tb_branch_resolve_unit;

  localparam int unsigned FC   = 2;
  localparam int unsigned CW   = 5;
  localparam int unsigned CMAX = (2 ** CW) - 1;

  logic          Clk;
  logic          Rst_n;
  logic          Valid_in;
  logic [2:0]    BrType;
  logic [31:0]   PC_in;
  logic [31:0]   Offset;
  logic          beq, blt, bgt, bltz, bgtz;
  logic          Stall;
  logic          PCSrc;
  logic [31:0]   BranchTarget;
  logic          Flush;
  logic          Busy;
  logic [CW-1:0] BranchCount;
  logic [CW-1:0] TakenCount;

  branch_resolve_unit #(.FLUSH_CYCLES(FC), .COUNT_W(CW)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .Valid_in(Valid_in), .BrType(BrType),
    .PC_in(PC_in), .Offset(Offset), .beq(beq), .blt(blt), .bgt(bgt),
    .bltz(bltz), .bgtz(bgtz), .Stall(Stall), .PCSrc(PCSrc),
    .BranchTarget(BranchTarget), .Flush(Flush), .Busy(Busy),
    .BranchCount(BranchCount), .TakenCount(TakenCount)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    logic          taken;
    logic [31:0]   target;
    int unsigned   pre;
    logic [CW-1:0] bc;
    logic [CW-1:0] tc;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  int unsigned m_bc = 0;
  int unsigned m_tc = 0;

  int unsigned pcs_n = 0, fl_n = 0, pre_n = 0;
  logic [31:0] tgt_seen = '0;
  logic        prev_busy = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", name, act, exp);
    end
  endtask

  // Monitor: one record per completed branch.
  initial begin
    exp_t e;
    forever begin
      @(negedge Clk);
      if (!Rst_n) begin
        pcs_n = 0; fl_n = 0; pre_n = 0; prev_busy = 1'b0;
      end else begin
        if (PCSrc) begin
          pcs_n++;
          tgt_seen = BranchTarget;
        end
        if (Flush) fl_n++;
        if (Busy && !PCSrc && !Flush) pre_n++;
        if (prev_busy && !Busy) begin
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_branch got=busy_pulse expected=none");
          end else begin
            e = sb.pop_front();
            chk("pcsrc_pulses", pcs_n, e.taken ? 32'd1 : 32'd0);
            chk("eval_cycles", pre_n, e.pre);
            chk("flush_cycles", fl_n, e.taken ? FC : 32'd0);
            if (e.taken) chk("target", tgt_seen, e.target);
            chk("branch_count", 32'(BranchCount), 32'(e.bc));
            chk("taken_count", 32'(TakenCount), 32'(e.tc));
          end
          pcs_n = 0; fl_n = 0; pre_n = 0;
        end
        prev_busy = Busy;
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    @(negedge Clk);
    while (Busy && n < 100) begin
      @(negedge Clk);
      n++;
    end
    if (n >= 100) chk("idle_timeout", 32'(Busy), 32'd0);
  endtask

  // flags = {beq, blt, bgt, bltz, bgtz}
  task automatic issue(input logic [2:0] bt, input logic [31:0] pc, input logic [31:0] off,
                       input logic [4:0] flags, input int unsigned stall_n,
                       input logic exp_taken, input logic [31:0] exp_tgt, input logic hold_valid);
    exp_t e;
    wait_idle();
    BrType = bt; PC_in = pc; Offset = off;
    {beq, blt, bgt, bltz, bgtz} = flags;
    Valid_in = 1'b1; Stall = 1'b0;
    if (m_bc < CMAX) m_bc++;
    if (exp_taken && m_tc < CMAX) m_tc++;
    e.taken = exp_taken; e.target = exp_tgt; e.pre = 1 + stall_n;
    e.bc = CW'(m_bc); e.tc = CW'(m_tc);
    sb.push_back(e);
    @(negedge Clk);
    if (hold_valid) begin
      BrType = 3'd7; PC_in = 32'hDEAD_0000;
    end else begin
      Valid_in = 1'b0;
    end
    Stall = (stall_n != 0);
    repeat (stall_n) @(negedge Clk);
    Stall = 1'b0;
    if (hold_valid) begin
      @(negedge Clk);
      Valid_in = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    Rst_n = 1'b0; Valid_in = 1'b0; BrType = '0; PC_in = '0; Offset = '0;
    {beq, blt, bgt, bltz, bgtz} = '0; Stall = 1'b0;
    repeat (3) @(negedge Clk);
    chk("reset_pcsrc", 32'(PCSrc), 32'd0);
    chk("reset_flush", 32'(Flush), 32'd0);
    chk("reset_busy", 32'(Busy), 32'd0);
    chk("reset_target", BranchTarget, 32'd0);
    chk("reset_bcount", 32'(BranchCount), 32'd0);
    #2 Rst_n = 1'b1;

    issue(3'd1, 32'h0000_0100, 32'h0000_0004, 5'b10000, 0, 1'b1, 32'h0000_0114, 1'b0);
    issue(3'd2, 32'h0000_0200, 32'h0000_0004, 5'b10000, 0, 1'b0, 32'h0, 1'b0);
    issue(3'd3, 32'h0000_0040, 32'hFFFF_FFF0, 5'b01000, 0, 1'b1, 32'h0000_0004, 1'b0);
    issue(3'd7, 32'hFFFF_FFFC, 32'h0000_0000, 5'b00000, 0, 1'b1, 32'h0000_0000, 1'b0);
    issue(3'd4, 32'h0000_1000, 32'h0000_0010, 5'b00100, 3, 1'b1, 32'h0000_1044, 1'b1);
    issue(3'd5, 32'h0000_0300, 32'h0000_0008, 5'b11101, 0, 1'b0, 32'h0, 1'b0);
    issue(3'd6, 32'h0000_0080, 32'hFFFF_FFFF, 5'b00001, 0, 1'b1, 32'h0000_0080, 1'b0);
    issue(3'd7, 32'h0000_0000, 32'hC000_0001, 5'b00000, 0, 1'b1, 32'h0000_0008, 1'b0);
    issue(3'd1, 32'h0000_0500, 32'h0000_0004, 5'b01111, 0, 1'b0, 32'h0, 1'b0);
    issue(3'd3, 32'h0000_0600, 32'h0000_0004, 5'b10111, 2, 1'b0, 32'h0, 1'b0);

    // Valid with Stall in IDLE must not capture.
    wait_idle();
    BrType = 3'd1; beq = 1'b1; Valid_in = 1'b1; Stall = 1'b1;
    repeat (3) begin
      @(negedge Clk);
      chk("stall_idle_busy", 32'(Busy), 32'd0);
    end
    Valid_in = 1'b0; Stall = 1'b0;
    chk("target_held", BranchTarget, 32'h0000_0008);

    // Asynchronous reset in the middle of FLUSH.
    wait_idle();
    BrType = 3'd7; PC_in = 32'h0000_0700; Offset = '0; Valid_in = 1'b1;
    @(negedge Clk);
    Valid_in = 1'b0;
    @(posedge Clk);
    #2 chk("pre_reset_flush", 32'(Flush), 32'd1);
    #1 Rst_n = 1'b0;
    #1;
    chk("abort_pcsrc", 32'(PCSrc), 32'd0);
    chk("abort_flush", 32'(Flush), 32'd0);
    chk("abort_busy", 32'(Busy), 32'd0);
    chk("abort_bcount", 32'(BranchCount), 32'd0);
    chk("abort_tcount", 32'(TakenCount), 32'd0);
    @(negedge Clk);
    #2 Rst_n = 1'b1;
    m_bc = 0; m_tc = 0;
    repeat (5) begin
      @(negedge Clk);
      chk("post_reset_pcsrc", 32'(PCSrc), 32'd0);
      chk("post_reset_busy", 32'(Busy), 32'd0);
    end

    // Saturation: 2^CW + 3 taken jumps.
    for (int i = 0; i < (2 ** CW) + 3; i++)
      issue(3'd7, 32'(i * 16), 32'h0, 5'b00000, 0, 1'b1, 32'(i * 16 + 4), 1'b0);

    wait_idle();
    repeat (3) @(negedge Clk);
    chk("sat_bcount", 32'(BranchCount), CMAX);
    chk("sat_tcount", 32'(TakenCount), CMAX);
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    chk("stray_pcsrc", pcs_n, 32'd0);
    chk("stray_flush", fl_n, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
